// File: rtl/pc_flow_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the program-counter flow controller.
package pc_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        PCF_RUN   = 2'd0,
        PCF_FLUSH = 2'd1,
        PCF_STALL = 2'd2,
        PCF_HALT  = 2'd3
    } pcf_state_e;

    localparam int PCF_PERF_W = 32;

    // Bits needed to hold the largest countdown load value (max_cycles - 1).
    function automatic int pcf_cnt_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/pc_flow_ctrl_cnt.sv
// Loadable down-counter for the FLUSH/STALL countdown; holds at zero when
// decremented there, and load takes precedence over decrement.
module pc_flow_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             ip_clk,
    input  logic             ip_rst,
    input  logic             ip_load,
    input  logic [WIDTH-1:0] ip_load_val,
    input  logic             ip_dec,
    output logic [WIDTH-1:0] op_count,
    output logic             op_zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (ip_load) begin
            count_d = ip_load_val;
        end else if (ip_dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign op_count = count_q;
    assign op_zero  = (count_q == '0);

endmodule

// File: rtl/pc_flow_ctrl.sv
// Program-counter flow controller: merges load-use stalls and EX redirects, flushes
// IF/ID and ID/EX, and latches program completion. PC_FLOW_PERF_EN adds perf counters.
//
// state | meaning
// RUN   | normal fetch; accepts done, redirect, load-use
// FLUSH | squashing wrong-path instructions after a redirect
// STALL | holding the pc for a multi-cycle load-use stall
// HALT  | program finished, fetch frozen until ip_rst
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CYCLES = 1
) (
    input  logic                  ip_clk,
    input  logic                  ip_rst,
    input  logic                  ip_load_use,
    input  logic                  ip_jump,
    input  logic [ADDR_WIDTH-1:0] ip_jump_addr,
    input  logic                  ip_branch_taken,
    input  logic [ADDR_WIDTH-1:0] ip_branch_addr,
    input  logic                  ip_done_execute,
    output logic                  op_stall_ctrl,
    output logic                  op_jump_branch_ctrl,
    output logic [ADDR_WIDTH-1:0] op_target_addr,
    output logic                  op_flush_if_id,
    output logic                  op_flush_id_ex,
    output logic                  op_halt,
    output logic [1:0]            op_state
`ifdef PC_FLOW_PERF_EN
    ,
    output logic [PCF_PERF_W-1:0] op_stall_count,
    output logic [PCF_PERF_W-1:0] op_redirect_count
`endif
);

    localparam int CNT_MAX = (FLUSH_CYCLES > STALL_CYCLES) ? FLUSH_CYCLES : STALL_CYCLES;
    localparam int CNT_W   = pcf_cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0]      FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]      STALL_LOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    pcf_state_e state_q;
    pcf_state_e state_d;

    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_dec;
    logic [CNT_W-1:0]      cnt_count;
    logic                  cnt_zero;
    logic                  redirect_req;
    logic [ADDR_WIDTH-1:0] redirect_addr;

    assign redirect_req  = ip_jump | ip_branch_taken;
    assign redirect_addr = (ip_jump ? ip_jump_addr : ip_branch_addr) & ALIGN_MASK;

    pc_flow_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .ip_clk      (ip_clk),
        .ip_rst      (ip_rst),
        .ip_load     (cnt_load),
        .ip_load_val (cnt_load_val),
        .ip_dec      (cnt_dec),
        .op_count    (cnt_count),
        .op_zero     (cnt_zero)
    );

    always_comb begin
        state_d             = state_q;
        cnt_load            = 1'b0;
        cnt_load_val        = '0;
        cnt_dec             = 1'b0;
        op_stall_ctrl       = 1'b0;
        op_jump_branch_ctrl = 1'b0;
        op_target_addr      = '0;
        op_flush_if_id      = 1'b0;
        op_flush_id_ex      = 1'b0;
        op_halt             = 1'b0;
        op_state            = state_q;

        case (state_q)
            PCF_RUN, PCF_STALL: begin
                if (ip_done_execute) begin
                    op_stall_ctrl = 1'b1;
                    op_halt       = 1'b1;
                    state_d       = PCF_HALT;
                end else if (redirect_req) begin
                    // A redirect also aborts an ongoing stall.
                    op_jump_branch_ctrl = 1'b1;
                    op_target_addr      = redirect_addr;
                    op_flush_if_id      = 1'b1;
                    op_flush_id_ex      = 1'b1;
                    cnt_load            = 1'b1;
                    cnt_load_val        = FLUSH_LOAD;
                    state_d             = PCF_FLUSH;
                end else if (state_q == PCF_STALL) begin
                    op_stall_ctrl  = 1'b1;
                    op_flush_id_ex = 1'b1;
                    cnt_dec        = 1'b1;
                    // The RUN cycle that raised the stall is the first stall cycle.
                    if (cnt_count <= CNT_W'(1)) begin
                        state_d = PCF_RUN;
                    end
                end else if (ip_load_use) begin
                    op_stall_ctrl  = 1'b1;
                    op_flush_id_ex = 1'b1;
                    cnt_load       = 1'b1;
                    cnt_load_val   = STALL_LOAD;
                    state_d        = (STALL_CYCLES > 1) ? PCF_STALL : PCF_RUN;
                end
            end
            PCF_FLUSH: begin
                op_flush_if_id = 1'b1;
                op_flush_id_ex = 1'b1;
                if (ip_done_execute) begin
                    op_stall_ctrl = 1'b1;
                    op_halt       = 1'b1;
                    state_d       = PCF_HALT;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_zero) begin
                        state_d = PCF_RUN;
                    end
                end
            end
            PCF_HALT: begin
                op_stall_ctrl = 1'b1;
                op_halt       = 1'b1;
            end
            default: begin
                state_d = PCF_RUN;
            end
        endcase

        if (ip_rst) begin
            op_stall_ctrl       = 1'b0;
            op_jump_branch_ctrl = 1'b0;
            op_target_addr      = '0;
            op_flush_if_id      = 1'b0;
            op_flush_id_ex      = 1'b0;
            op_halt             = 1'b0;
            op_state            = 2'd0;
            cnt_load            = 1'b0;
            cnt_dec             = 1'b0;
        end
    end

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            state_q <= PCF_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PC_FLOW_PERF_EN
    logic [PCF_PERF_W-1:0] stall_cnt_q;
    logic [PCF_PERF_W-1:0] stall_cnt_d;
    logic [PCF_PERF_W-1:0] redir_cnt_q;
    logic [PCF_PERF_W-1:0] redir_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (op_stall_ctrl && (state_q != PCF_HALT)) begin
            stall_cnt_d = stall_cnt_q + PCF_PERF_W'(1);
        end
        if (op_jump_branch_ctrl) begin
            redir_cnt_d = redir_cnt_q + PCF_PERF_W'(1);
        end
    end

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign op_stall_count    = stall_cnt_q;
    assign op_redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: directed vector table, HALT/reset sequences,
// random stimulus against a remaining-cycles reference model; perf checks under PC_FLOW_PERF_EN.
module tb_pc_flow_ctrl;

    localparam int AW = 32;
    localparam int FC = 1;
    localparam int SC = 3;

    typedef struct packed {
        logic          rst;
        logic          lu;
        logic          jmp;
        logic [AW-1:0] jaddr;
        logic          br;
        logic [AW-1:0] baddr;
        logic          done;
    } ins_t;

    typedef struct packed {
        logic          stall;
        logic          jb;
        logic [AW-1:0] tgt;
        logic          fif;
        logic          fie;
        logic          halt;
        logic [1:0]    state;
    } outs_t;

    typedef struct packed {
        ins_t  ins;
        outs_t exp;
    } vec_t;

    logic          ip_clk;
    logic          ip_rst;
    logic          ip_load_use;
    logic          ip_jump;
    logic [AW-1:0] ip_jump_addr;
    logic          ip_branch_taken;
    logic [AW-1:0] ip_branch_addr;
    logic          ip_done_execute;
    logic          op_stall_ctrl;
    logic          op_jump_branch_ctrl;
    logic [AW-1:0] op_target_addr;
    logic          op_flush_if_id;
    logic          op_flush_id_ex;
    logic          op_halt;
    logic [1:0]    op_state;
`ifdef PC_FLOW_PERF_EN
    logic [31:0]   op_stall_count;
    logic [31:0]   op_redirect_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining FLUSH / STALL cycles plus a halted flag.
    bit          m_valid = 0;
    bit          m_halted = 0;
    int          m_flush_left = 0;
    int          m_stall_left = 0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_redir_cnt = '0;

    pc_flow_ctrl #(
        .ADDR_WIDTH   (AW),
        .FLUSH_CYCLES (FC),
        .STALL_CYCLES (SC)
    ) dut (
        .ip_clk              (ip_clk),
        .ip_rst              (ip_rst),
        .ip_load_use         (ip_load_use),
        .ip_jump             (ip_jump),
        .ip_jump_addr        (ip_jump_addr),
        .ip_branch_taken     (ip_branch_taken),
        .ip_branch_addr      (ip_branch_addr),
        .ip_done_execute     (ip_done_execute),
        .op_stall_ctrl       (op_stall_ctrl),
        .op_jump_branch_ctrl (op_jump_branch_ctrl),
        .op_target_addr      (op_target_addr),
        .op_flush_if_id      (op_flush_if_id),
        .op_flush_id_ex      (op_flush_id_ex),
        .op_halt             (op_halt),
        .op_state            (op_state)
`ifdef PC_FLOW_PERF_EN
        ,
        .op_stall_count      (op_stall_count),
        .op_redirect_count   (op_redirect_count)
`endif
    );

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    function automatic ins_t mk_in(input logic rst, input logic lu, input logic jmp,
                                   input logic [AW-1:0] jaddr, input logic br,
                                   input logic [AW-1:0] baddr, input logic done);
        ins_t i;
        i = '{rst: rst, lu: lu, jmp: jmp, jaddr: jaddr, br: br, baddr: baddr, done: done};
        return i;
    endfunction

    function automatic outs_t mk_out(input logic stall, input logic jb, input logic [AW-1:0] tgt,
                                     input logic fif, input logic fie, input logic halt,
                                     input logic [1:0] state);
        outs_t o;
        o = '{stall: stall, jb: jb, tgt: tgt, fif: fif, fie: fie, halt: halt, state: state};
        return o;
    endfunction

    function automatic outs_t model_out(input ins_t i);
        outs_t o;
        o = '0;
        if (i.rst) return o;
        if (m_halted)               o.state = 2'd3;
        else if (m_flush_left > 0)  o.state = 2'd1;
        else if (m_stall_left > 0)  o.state = 2'd2;
        else                        o.state = 2'd0;
        if (m_halted) begin
            o.stall = 1'b1;
            o.halt  = 1'b1;
        end else if (i.done) begin
            o.stall = 1'b1;
            o.halt  = 1'b1;
            if (m_flush_left > 0) begin
                o.fif = 1'b1;
                o.fie = 1'b1;
            end
        end else if (m_flush_left > 0) begin
            o.fif = 1'b1;
            o.fie = 1'b1;
        end else if (i.jmp || i.br) begin
            o.jb  = 1'b1;
            o.tgt = (i.jmp ? i.jaddr : i.baddr) & ~32'h3;
            o.fif = 1'b1;
            o.fie = 1'b1;
        end else if ((m_stall_left > 0) || i.lu) begin
            o.stall = 1'b1;
            o.fie   = 1'b1;
        end
        return o;
    endfunction

    task automatic model_advance(input ins_t i, input outs_t o);
        if (i.rst) begin
            m_valid      = 1;
            m_halted     = 0;
            m_flush_left = 0;
            m_stall_left = 0;
            m_stall_cnt  = '0;
            m_redir_cnt  = '0;
            return;
        end
        if (o.stall && !m_halted) m_stall_cnt = m_stall_cnt + 32'd1;
        if (o.jb)                 m_redir_cnt = m_redir_cnt + 32'd1;
        if (m_halted) begin
        end else if (i.done) begin
            m_halted     = 1;
            m_flush_left = 0;
            m_stall_left = 0;
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (i.jmp || i.br) begin
            m_flush_left = FC;
            m_stall_left = 0;
        end else if (m_stall_left > 0) begin
            m_stall_left = m_stall_left - 1;
        end else if (i.lu) begin
            m_stall_left = SC - 1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive after the edge, sample before the next, keep the model in step.
    task automatic cycle(input ins_t i, output outs_t act, output outs_t mexp);
        @(posedge ip_clk);
        #1;
        ip_rst          = i.rst;
        ip_load_use     = i.lu;
        ip_jump         = i.jmp;
        ip_jump_addr    = i.jaddr;
        ip_branch_taken = i.br;
        ip_branch_addr  = i.baddr;
        ip_done_execute = i.done;
        #3;
        act  = {op_stall_ctrl, op_jump_branch_ctrl, op_target_addr,
                op_flush_if_id, op_flush_id_ex, op_halt, op_state};
        mexp = model_out(i);
`ifdef PC_FLOW_PERF_EN
        if (m_valid) begin
            check("perf_stall_model", 64'(op_stall_count), 64'(m_stall_cnt));
            check("perf_redir_model", 64'(op_redirect_count), 64'(m_redir_cnt));
        end
`endif
        model_advance(i, mexp);
    endtask

    initial begin
        vec_t  vecs[$];
        outs_t act;
        outs_t mexp;
        outs_t halt_o;
        outs_t zero_o;
        ins_t  idle;
        ins_t  r;

        ip_rst          = 1'b1;
        ip_load_use     = 1'b0;
        ip_jump         = 1'b0;
        ip_jump_addr    = '0;
        ip_branch_taken = 1'b0;
        ip_branch_addr  = '0;
        ip_done_execute = 1'b0;

        idle   = mk_in(0, 0, 0, 32'h0, 0, 32'h0, 0);
        zero_o = mk_out(0, 0, 32'h0, 0, 0, 0, 2'd0);
        halt_o = mk_out(1, 0, 32'h0, 0, 0, 1, 2'd3);

        vecs.push_back('{mk_in(1, 1, 1, 32'h44, 1, 32'h48, 1), zero_o});
        vecs.push_back('{mk_in(1, 0, 0, 32'h0, 1, 32'h8, 0),   zero_o});
        vecs.push_back('{mk_in(0, 0, 0, 32'h0, 1, 32'h10, 0),  mk_out(0, 1, 32'h10, 1, 1, 0, 2'd0)});
        vecs.push_back('{mk_in(0, 0, 1, 32'h80, 1, 32'h84, 0), mk_out(0, 0, 32'h0, 1, 1, 0, 2'd1)});
        vecs.push_back('{idle,                                 zero_o});
        vecs.push_back('{mk_in(0, 0, 1, 32'h20, 1, 32'h40, 0), mk_out(0, 1, 32'h20, 1, 1, 0, 2'd0)});
        vecs.push_back('{mk_in(0, 1, 0, 32'h0, 0, 32'h0, 0),   mk_out(0, 0, 32'h0, 1, 1, 0, 2'd1)});
        vecs.push_back('{mk_in(0, 0, 1, 32'h23, 0, 32'h0, 0),  mk_out(0, 1, 32'h20, 1, 1, 0, 2'd0)});
        vecs.push_back('{idle,                                 mk_out(0, 0, 32'h0, 1, 1, 0, 2'd1)});
        vecs.push_back('{mk_in(0, 1, 0, 32'h0, 0, 32'h0, 0),   mk_out(1, 0, 32'h0, 0, 1, 0, 2'd0)});
        vecs.push_back('{idle,                                 mk_out(1, 0, 32'h0, 0, 1, 0, 2'd2)});
        vecs.push_back('{idle,                                 mk_out(1, 0, 32'h0, 0, 1, 0, 2'd2)});
        vecs.push_back('{idle,                                 zero_o});
        vecs.push_back('{mk_in(0, 1, 0, 32'h0, 0, 32'h0, 0),   mk_out(1, 0, 32'h0, 0, 1, 0, 2'd0)});
        vecs.push_back('{mk_in(0, 0, 1, 32'h100, 0, 32'h0, 0), mk_out(0, 1, 32'h100, 1, 1, 0, 2'd2)});
        vecs.push_back('{idle,                                 mk_out(0, 0, 32'h0, 1, 1, 0, 2'd1)});
        vecs.push_back('{idle,                                 zero_o});
        vecs.push_back('{mk_in(0, 1, 0, 32'h0, 1, 32'h1ff, 0), mk_out(0, 1, 32'h1fc, 1, 1, 0, 2'd0)});
        vecs.push_back('{idle,                                 mk_out(0, 0, 32'h0, 1, 1, 0, 2'd1)});
        vecs.push_back('{idle,                                 zero_o});
        vecs.push_back('{mk_in(0, 0, 1, 32'h30, 0, 32'h0, 1),  mk_out(1, 0, 32'h0, 0, 0, 1, 2'd0)});
        vecs.push_back('{mk_in(0, 1, 1, 32'h34, 1, 32'h38, 0), halt_o});

        foreach (vecs[k]) begin
            cycle(vecs[k].ins, act, mexp);
            check($sformatf("vec%0d", k), 64'(act), 64'(vecs[k].exp));
        end

        // HALT holds for ten cycles whatever the other inputs do.
        for (int k = 0; k < 10; k++) begin
            r = mk_in(0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom));
            cycle(r, act, mexp);
            check($sformatf("halt_hold%0d", k), 64'(act), 64'(halt_o));
        end
        cycle(mk_in(1, 0, 1, 32'h50, 0, 32'h0, 0), act, mexp);
        check("halt_reset", 64'(act), 64'(zero_o));
        cycle(idle, act, mexp);
        check("run_after_reset", 64'(act), 64'(zero_o));

        for (int k = 0; k < 3000; k++) begin
            r.rst   = ($urandom_range(0, 63) == 0);
            r.done  = ($urandom_range(0, 149) == 0);
            r.lu    = ($urandom_range(0, 3) == 0);
            r.jmp   = ($urandom_range(0, 7) == 0);
            r.br    = ($urandom_range(0, 5) == 0);
            r.jaddr = $urandom;
            r.baddr = $urandom;
            cycle(r, act, mexp);
            if (act !== mexp) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand%0d: got %h expected %h", k, act, mexp);
            end else begin
                n_checks++;
            end
        end

`ifdef PC_FLOW_PERF_EN
        cycle(mk_in(1, 0, 0, 32'h0, 0, 32'h0, 0), act, mexp);
        cycle(mk_in(0, 0, 1, 32'h40, 0, 32'h0, 0), act, mexp);
        cycle(idle, act, mexp);
        cycle(mk_in(0, 0, 0, 32'h0, 1, 32'h80, 0), act, mexp);
        cycle(idle, act, mexp);
        cycle(mk_in(0, 1, 0, 32'h0, 0, 32'h0, 0), act, mexp);
        cycle(idle, act, mexp);
        cycle(idle, act, mexp);
        cycle(mk_in(0, 0, 0, 32'h0, 0, 32'h0, 1), act, mexp);
        cycle(idle, act, mexp);
        cycle(idle, act, mexp);
        cycle(idle, act, mexp);
        check("perf_redirect_2", 64'(op_redirect_count), 64'd2);
        check("perf_stall_4", 64'(op_stall_count), 64'd4);
        cycle(mk_in(1, 0, 0, 32'h0, 0, 32'h0, 0), act, mexp);
        cycle(idle, act, mexp);
        check("perf_redirect_clr", 64'(op_redirect_count), 64'd0);
        check("perf_stall_clr", 64'(op_stall_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
